if_id_decode: RTL and testbench

IF_ID_DECODE -- requirements
Module: if_id_decode

---
 rtl/if_id_decode.sv | 118 +++++++++++
 tb/tb_if_id_decode.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with combinational field decode, immediate extension and load-use hazard stall.
// Build option: define HAZARD_DETECT_EN to enable stall detection, the EX bubble and the stall counter.
module if_id_decode (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Instr_In,
  input  logic [31:0] PC_In,
  input  logic        Valid_In,
  input  logic        Flush,
  input  logic        Ex_MemRead,
  input  logic [4:0]  Ex_Rt,
  output logic [4:0]  Read_Register1,
  output logic [4:0]  Read_Register2,
  output logic [4:0]  Dest_Register,
  output logic [31:0] Imm_Ext,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [31:0] PC_Out,
  output logic        Valid_Out,
  output logic        Stall_Out,
  output logic        Ex_Bubble,
  output logic [15:0] Stall_Count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [4:0] REG_RA   = 5'd31;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
    logic signed [15:0] imm_s;
    imm_s = imm;
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
      return {16'h0000, imm};
    return 32'(imm_s);
  endfunction

`ifdef HAZARD_DETECT_EN
  // Load-use hazard: the load in EX writes a register this instruction reads.
  always_comb begin
    stall = valid_q && Ex_MemRead && (Ex_Rt != 5'd0) &&
            ((Ex_Rt == instr_q[25:21]) || (Ex_Rt == instr_q[20:16]));
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall)
      stall_cnt_d = sat_inc16(stall_cnt_q);
  end
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{Ex_MemRead, Ex_Rt, sat_inc16(stall_cnt_q)};
  assign stall       = 1'b0;
  assign stall_cnt_d = 16'h0000;
`endif

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (Flush) begin
      instr_d = 32'h0;
      pc_d    = 32'h0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = Valid_In ? Instr_In : 32'h0;
      pc_d    = PC_In;
      valid_d = Valid_In;
    end
  end

  // IF/ID stage boundary
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      instr_q     <= 32'h0;
      pc_q        <= 32'h0;
      valid_q     <= 1'b0;
      stall_cnt_q <= 16'h0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    Opcode         = instr_q[31:26];
    Read_Register1 = instr_q[25:21];
    Read_Register2 = instr_q[20:16];
    Funct          = instr_q[5:0];
    Imm_Ext        = ext_imm(instr_q[31:26], instr_q[15:0]);
    case (instr_q[31:26])
      OP_RTYPE: Dest_Register = instr_q[15:11];
      OP_JAL:   Dest_Register = REG_RA;
      default:  Dest_Register = instr_q[20:16];
    endcase
  end

  assign PC_Out      = pc_q;
  assign Valid_Out   = valid_q;
  assign Stall_Out   = stall;
  assign Ex_Bubble   = stall;
  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_if_id_decode.sv
// Scoreboard bench for if_id_decode: driver pushes model predictions, monitor pops and compares.
module tb_if_id_decode;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Instr_In = '0, PC_In = '0;
  logic        Valid_In = 1'b0, Flush = 1'b0, Ex_MemRead = 1'b0;
  logic [4:0]  Ex_Rt = '0;
  logic [4:0]  Read_Register1, Read_Register2, Dest_Register;
  logic [31:0] Imm_Ext, PC_Out;
  logic [5:0]  Opcode, Funct;
  logic        Valid_Out, Stall_Out, Ex_Bubble;
  logic [15:0] Stall_Count;

  if_id_decode dut (
    .Clock(Clock), .Reset(Reset), .Instr_In(Instr_In), .PC_In(PC_In),
    .Valid_In(Valid_In), .Flush(Flush), .Ex_MemRead(Ex_MemRead), .Ex_Rt(Ex_Rt),
    .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
    .Dest_Register(Dest_Register), .Imm_Ext(Imm_Ext), .Opcode(Opcode), .Funct(Funct),
    .PC_Out(PC_Out), .Valid_Out(Valid_Out), .Stall_Out(Stall_Out),
    .Ex_Bubble(Ex_Bubble), .Stall_Count(Stall_Count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [4:0]  rr1, rr2, dest;
    logic [31:0] imm;
    logic [5:0]  op, fn;
    logic [31:0] pc;
    logic        vld, stall, bub;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Architectural model state: what the IF/ID latch holds.
  logic [31:0] m_instr = '0, m_pc = '0;
  logic        m_valid = 1'b0;
  int          m_cnt = 0;

  function automatic bit hazard(input logic [31:0] ins, input logic v, input logic mr, input logic [4:0] rt);
`ifdef HAZARD_DETECT_EN
    int rs_f, rt_f;
    rs_f = int'(ins >> 21) % 32;
    rt_f = int'(ins >> 16) % 32;
    return v && mr && rt != 0 && (int'(rt) == rs_f || int'(rt) == rt_f);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int op, imm;
    op  = int'(m_instr >> 26);
    imm = int'(m_instr % 65536);
    e.op   = 6'(op);
    e.rr1  = 5'(int'(m_instr >> 21) % 32);
    e.rr2  = 5'(int'(m_instr >> 16) % 32);
    e.fn   = 6'(int'(m_instr % 64));
    if (op == 0)      e.dest = 5'(int'(m_instr >> 11) % 32);
    else if (op == 3) e.dest = 5'd31;
    else              e.dest = e.rr2;
    if (op >= 12 && op <= 14 || imm < 32768) e.imm = 32'(imm);
    else                                     e.imm = 32'(imm) + 32'hFFFF0000;
    e.pc    = m_pc;
    e.vld   = m_valid;
    e.stall = hazard(m_instr, m_valid, Ex_MemRead, Ex_Rt);
    e.bub   = e.stall;
    e.cnt   = 16'(m_cnt);
    return e;
  endfunction

  function automatic bit chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Drive one cycle of inputs at the falling edge, predict, then advance the model at the rising edge.
  task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic vin,
                       input logic fl, input logic mr, input logic [4:0] rt, input bit check);
    bit st;
    @(negedge Clock);
    Instr_In = ins; PC_In = pc; Valid_In = vin; Flush = fl; Ex_MemRead = mr; Ex_Rt = rt;
    #1;
    if (check) exp_q.push_back(predict());
    st = hazard(m_instr, m_valid, mr, rt);
    @(posedge Clock);
    if (Reset) begin
      if (fl) begin
        m_instr = 0; m_pc = 0; m_valid = 0;
      end else if (!st) begin
        m_instr = vin ? ins : 32'h0; m_pc = pc; m_valid = vin;
      end
      if (st && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic async_reset_check();
    @(negedge Clock);
    #2;
    Reset = 1'b0;
    m_instr = 0; m_pc = 0; m_valid = 0; m_cnt = 0;
    #1;
    exp_q.push_back(predict());
    #3;
    Reset = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit bad;
    forever begin
      wait (exp_q.size() > 0);
      #1;
      e = exp_q.pop_front();
      bad = 1'b0;
      bad |= chk("Read_Register1", 32'(Read_Register1), 32'(e.rr1));
      bad |= chk("Read_Register2", 32'(Read_Register2), 32'(e.rr2));
      bad |= chk("Dest_Register",  32'(Dest_Register),  32'(e.dest));
      bad |= chk("Imm_Ext",        Imm_Ext,             e.imm);
      bad |= chk("Opcode",         32'(Opcode),         32'(e.op));
      bad |= chk("Funct",          32'(Funct),          32'(e.fn));
      bad |= chk("PC_Out",         PC_Out,              e.pc);
      bad |= chk("Valid_Out",      32'(Valid_Out),      32'(e.vld));
      bad |= chk("Stall_Out",      32'(Stall_Out),      32'(e.stall));
      bad |= chk("Ex_Bubble",      32'(Ex_Bubble),      32'(e.bub));
      bad |= chk("Stall_Count",    32'(Stall_Count),    32'(e.cnt));
      vectors++;
      if (bad) miscompares++;
    end
  end

  // Driver
  initial begin
    logic [31:0] ins;
    logic [4:0]  rt;
    int          waited;
    #3;
    exp_q.push_back(predict());
    @(negedge Clock);
    #2;
    Reset = 1'b1;

    cycle(32'h012A4020, 32'h00400000, 1, 0, 0, 5'd0, 1);
    cycle(32'h11111111, 32'h00400004, 1, 0, 1, 5'd9, 1);   // rs match
    cycle(32'h11111111, 32'h00400004, 1, 0, 1, 5'd10, 1);  // rt match
    cycle(32'h11111111, 32'h00400004, 1, 0, 1, 5'd0, 1);   // Ex_Rt zero
    cycle(32'h012A4020, 32'h00400010, 1, 0, 0, 5'd0, 1);
    cycle(32'h22222222, 32'h00400014, 1, 1, 1, 5'd9, 1);   // flush with stall
    cycle(32'h34058000, 32'h00400018, 1, 0, 0, 5'd0, 1);
    cycle(32'h20058000, 32'h0040001C, 1, 0, 0, 5'd0, 1);
    cycle(32'h0C100000, 32'h00400020, 1, 0, 0, 5'd0, 1);
    cycle(32'h31237FFF, 32'h00400024, 0, 0, 0, 5'd0, 1);   // invalid slot
    cycle(32'h00000000, 32'h00400028, 1, 0, 0, 5'd0, 1);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:26] = 6'($urandom_range(0, 15));
      rt = ($urandom_range(0, 1) == 1) ? m_instr[25:21] : 5'($urandom_range(0, 31));
      cycle(ins, $urandom, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), rt, 1);
      if (i == 200) begin
        cycle(32'h012A4020, 32'h00400000, 1, 0, 0, 5'd0, 1);
        cycle(32'h012A4020, 32'h00400000, 1, 0, 1, 5'd9, 1);
        cycle(32'h012A4020, 32'h00400000, 1, 0, 1, 5'd9, 1);
        async_reset_check();
      end
    end

`ifdef HAZARD_DETECT_EN
    cycle(32'h012A4020, 32'h00400000, 1, 0, 0, 5'd0, 1);
    for (int i = 0; i < 70000; i++)
      cycle(32'h012A4020, 32'h00400000, 1, 0, 1, 5'd9, (i % 5000) == 0);
    cycle(32'h012A4020, 32'h00400000, 1, 0, 1, 5'd9, 1);
    cycle(32'h012A4020, 32'h00400000, 1, 0, 0, 5'd0, 1);
`endif

    waited = 0;
    while (exp_q.size() > 0 && waited < 100) begin
      @(posedge Clock);
      waited++;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      miscompares++;
    end
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
